rst_req_gen: RTL and testbench

RST_REQ_GEN -- requirements
Module: rst_req_gen

---
 rtl/rst_req_gen_if.sv | 17 +
 rtl/rst_req_gen.sv | 174 +++++++++++++++++
 tb/tb_rst_req_gen.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rst_req_gen_if.sv
// -----------------------------------------------------------------------------
// rst_req_gen_if
// Register bus between a debug host (master) and rst_req_gen (slave).
//   we_i    : write strobe, one cycle per write          (master -> slave)
//   addr_i  : register byte address (0x0/0x4/0x8)         (master -> slave)
//   data_i  : write data                                  (master -> slave)
//   data_o  : read data, combinational from addr_i        (slave  -> master)
// -----------------------------------------------------------------------------
interface rst_req_gen_if;
    logic        we_i;
    logic [3:0]  addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (output we_i, addr_i, data_i, input data_o);
    modport slave  (input we_i, addr_i, data_i, output data_o);
endinterface

// File: rtl/rst_req_gen.sv
// -----------------------------------------------------------------------------
// rst_req_gen
// Software-triggered core reset requester. A keyed CTRL write starts a
// sequence: a guard delay, a registered reset-request pulse of WIDTH cycles,
// then a bounded wait for the core reset feedback to be released. Sticky
// STATUS flags report completion, timeout and missing feedback.
//
// Ports:
//   clk        : clock, all logic on the rising edge
//   rst_n      : synchronous active-low reset, from the non-core reset domain
//   bus        : register bus (slave modport), CTRL 0x0 / WIDTH 0x4 / STATUS 0x8
//   rst_fb_n_i : core reset feedback, active-low
//   rst_req_o  : registered active-high core reset request
// -----------------------------------------------------------------------------
module rst_req_gen #(
    parameter int unsigned GUARD_CYCLES   = 4,    // 1..15
    parameter int unsigned TIMEOUT_CYCLES = 255   // 1..255
) (
    input  logic         clk,
    input  logic         rst_n,
    rst_req_gen_if.slave bus,
    input  logic         rst_fb_n_i,
    output logic         rst_req_o
);

    // Encoding doubles as the STATUS[2:1] state code.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GUARD    = 2'd1,
        ASSERT   = 2'd2,
        WAIT_REL = 2'd3
    } state_e;

    localparam logic [3:0]  ADDR_CTRL    = 4'h0;
    localparam logic [3:0]  ADDR_WIDTH   = 4'h4;
    localparam logic [3:0]  ADDR_STATUS  = 4'h8;
    localparam logic [15:0] START_KEY    = 16'h5AA5;
    localparam logic [7:0]  WIDTH_RST    = 8'd16;
    // Counters are loaded with (length - 1) and the phase ends when they hit 0,
    // so each phase lasts exactly its length and nothing ever wraps.
    localparam logic [7:0]  GUARD_LOAD   = 8'(GUARD_CYCLES - 1);
    localparam logic [7:0]  TIMEOUT_LOAD = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic [7:0]  width_q;       // software-visible WIDTH register
    logic [7:0]  width_lat_q;   // WIDTH captured at start, used for this pulse
    logic [7:0]  cnt_q;         // shared phase counter
    logic        fb_seen_q;     // feedback sampled low during the current ASSERT
    logic        done_q;
    logic        timeout_q;
    logic        no_fb_q;
    logic        rst_req_q;

    logic wr_ctrl;
    logic wr_width;
    logic wr_status;
    logic start;
    logic unused_data_bits;

    assign wr_ctrl   = bus.we_i && (bus.addr_i == ADDR_CTRL);
    assign wr_width  = bus.we_i && (bus.addr_i == ADDR_WIDTH);
    assign wr_status = bus.we_i && (bus.addr_i == ADDR_STATUS);

    // Starts outside IDLE are simply dropped: no queueing, no timing effect.
    assign start = wr_ctrl && (bus.data_i[31:16] == START_KEY) &&
                   bus.data_i[0] && (state_q == IDLE);

    // No register field lives in these write-data bits.
    assign unused_data_bits = ^bus.data_i[15:8];

    // NOTE: synchronous reset is the first branch of the clocked block, so it
    // wins over any in-flight sequence on the very edge it is sampled; WIDTH
    // and the flags are plain flops here, so they all take their reset value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rst_req_q   <= 1'b0;
            width_q     <= WIDTH_RST;
            width_lat_q <= 8'd0;
            cnt_q       <= 8'd0;
            fb_seen_q   <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            no_fb_q     <= 1'b0;
        end else begin
            if (wr_width) begin
                width_q <= bus.data_i[7:0];
            end

            // NOTE: non-blocking assignments make the last write in this block
            // win; the flag sets in the FSM below therefore override a
            // same-cycle write-1-to-clear.
            if (wr_status) begin
                if (bus.data_i[3]) done_q    <= 1'b0;
                if (bus.data_i[4]) timeout_q <= 1'b0;
                if (bus.data_i[5]) no_fb_q   <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= GUARD;
                        cnt_q       <= GUARD_LOAD;
                        width_lat_q <= width_q;
                        done_q      <= 1'b0;
                        timeout_q   <= 1'b0;
                        no_fb_q     <= 1'b0;
                    end
                end

                GUARD: begin
                    if (cnt_q == 8'd0) begin
                        state_q   <= ASSERT;
                        rst_req_q <= 1'b1;
                        fb_seen_q <= 1'b0;
                        // WIDTH of 0 behaves as a 1-cycle pulse.
                        cnt_q     <= (width_lat_q == 8'd0) ? 8'd0 : width_lat_q - 8'd1;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end

                ASSERT: begin
                    if (!rst_fb_n_i) begin
                        fb_seen_q <= 1'b1;
                    end
                    if (cnt_q == 8'd0) begin
                        state_q   <= WAIT_REL;
                        rst_req_q <= 1'b0;
                        cnt_q     <= TIMEOUT_LOAD;
                        // Include this final ASSERT sample as well.
                        if (!fb_seen_q && rst_fb_n_i) begin
                            no_fb_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end

                WAIT_REL: begin
                    // Release is tested before expiry so a release on the last
                    // counted cycle reports done rather than timeout.
                    if (rst_fb_n_i) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        cnt_q   <= 8'd0;
                    end else if (cnt_q == 8'd0) begin
                        state_q   <= IDLE;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign rst_req_o = rst_req_q;

    // NOTE: every output of a combinational block gets a default first, so no
    // address path can leave it unassigned and infer a latch.
    always_comb begin
        bus.data_o = 32'd0;
        case (bus.addr_i)
            ADDR_WIDTH:  bus.data_o = {24'd0, width_q};
            ADDR_STATUS: bus.data_o = {26'd0, no_fb_q, timeout_q, done_q,
                                       state_q, (state_q != IDLE)};
            default:     bus.data_o = 32'd0;   // CTRL and unmapped read as 0
        endcase
    end

endmodule

// File: tb/tb_rst_req_gen.sv
// -----------------------------------------------------------------------------
// tb_rst_req_gen
// Drives rst_req_gen through directed and randomized reset sequences. For each
// sequence the expected reset pulse and the expected STATUS value for every
// cycle are derived from interval arithmetic on the sequence parameters and
// queued; two monitors (pulse and read-back) pop and compare independently.
// -----------------------------------------------------------------------------
module tb_rst_req_gen;

    localparam int G   = 4;
    localparam int TMO = 255;

    localparam logic [3:0] A_CTRL   = 4'h0;
    localparam logic [3:0] A_WIDTH  = 4'h4;
    localparam logic [3:0] A_STATUS = 4'h8;
    localparam logic [31:0] START   = 32'h5AA5_0001;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic fb_n  = 1'b1;
    logic rst_req;

    rst_req_gen_if bus ();

    rst_req_gen #(
        .GUARD_CYCLES   (G),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .rst_fb_n_i (fb_n),
        .rst_req_o  (rst_req)
    );

    always #5 clk = ~clk;

    // Cycle index: after rising edge k, cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- scoreboards ----------------
    typedef struct { logic [31:0] exp; string name; } rd_exp_t;
    typedef struct { int start; int len; } pulse_t;

    rd_exp_t rd_q[$];
    pulse_t  pulse_q[$];
    bit      rd_chk = 1'b0;

    // Read-back monitor: compares data_o whenever a read was issued this cycle.
    always @(negedge clk) begin
        if (rd_chk) begin
            if (rd_q.size() == 0) begin
                check("rd_queue_underflow", 32'd1, 32'd0);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                check(e.name, bus.data_o, e.exp);
            end
        end
    end

    // Pulse monitor: measures each rst_req_o pulse and compares with the queue.
    bit req_prev = 1'b0;
    int rise_cyc = 0;
    always @(negedge clk) begin
        if (rst_req === 1'b1 && !req_prev) rise_cyc = cyc;
        if (rst_req !== 1'b1 && req_prev) begin
            if (pulse_q.size() == 0) begin
                check("unexpected_pulse", 32'(rise_cyc), 32'hFFFF_FFFF);
            end else begin
                pulse_t p;
                p = pulse_q.pop_front();
                check("pulse_start", 32'(rise_cyc), 32'(p.start));
                check("pulse_len", 32'(cyc - rise_cyc), 32'(p.len));
            end
        end
        req_prev = (rst_req === 1'b1);
    end

    // ---------------- drivers ----------------
    // One bus cycle; optionally queues an expected read value for this cycle.
    task automatic step(bit we, logic [3:0] addr, logic [31:0] data, bit fb,
                        bit chk, logic [31:0] exp, string name);
        bus.we_i   = we;
        bus.addr_i = addr;
        bus.data_i = data;
        fb_n       = fb;
        rd_chk     = chk;
        if (chk) begin
            rd_exp_t e;
            e.exp  = exp;
            e.name = name;
            rd_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    int width_reg = 16;   // model of the WIDTH register

    // wset<0: keep WIDTH; rel: WAIT_REL cycles feedback stays low (>=TMO times out);
    // clr: issue STATUS clears on the cycles flags get set; busy_w>=0: during
    // ASSERT write an ignored second start then WIDTH=busy_w.
    task automatic run_seq(int wset, bit low_assert, int rel, bit clr, int busy_w, string tag);
        int wcyc, a0, len, w0, n, e, bw;
        bit timed_out;
        logic [31:0] flags, wait_st;
        pulse_t p;

        if (wset >= 0) begin
            step(1'b1, A_WIDTH, 32'(wset), 1'b1, 1'b0, 32'd0, "");
            width_reg = wset;
        end
        step(1'b0, A_WIDTH, 32'd0, 1'b1, 1'b1, 32'(width_reg), {tag, ":width"});

        wcyc      = cyc;
        len       = (width_reg == 0) ? 1 : width_reg;
        a0        = wcyc + 1 + G;
        w0        = a0 + len;
        timed_out = (rel >= TMO);
        n         = timed_out ? TMO : rel + 1;
        e         = w0 + n;
        wait_st   = 32'h7 | (low_assert ? 32'h0 : 32'h20);
        flags     = (low_assert ? 32'h0 : 32'h20) | (timed_out ? 32'h10 : 32'h08);
        bw        = (busy_w >= 0 && len >= 3) ? a0 + $urandom_range(0, len - 3) : -10;
        p.start   = a0;
        p.len     = len;
        pulse_q.push_back(p);

        step(1'b1, A_CTRL, START, 1'b1, 1'b0, 32'd0, "");

        for (int c = wcyc + 1; c <= e + 2; c++) begin
            bit fb_v;
            logic [31:0] exp_v;
            fb_v = 1'b1;
            if (c >= a0 && c < w0)            fb_v = !low_assert;
            else if (c >= w0 && c < w0 + rel) fb_v = 1'b0;
            if (c < a0)       exp_v = 32'h3;
            else if (c < w0)  exp_v = 32'h5;
            else if (c < e)   exp_v = wait_st;
            else              exp_v = flags;

            if (c == bw) begin
                step(1'b1, A_CTRL, START, fb_v, 1'b0, 32'd0, "");
            end else if (c == bw + 1) begin
                step(1'b1, A_WIDTH, 32'(busy_w), fb_v, 1'b0, 32'd0, "");
                width_reg = busy_w;
            end else if (clr && c == w0 - 1) begin
                step(1'b1, A_STATUS, 32'h38, fb_v, 1'b0, 32'd0, "");
            end else if (clr && c == e - 1) begin
                step(1'b1, A_STATUS, 32'h18, fb_v, 1'b0, 32'd0, "");
            end else begin
                step(1'b0, A_STATUS, 32'd0, fb_v, 1'b1, exp_v, {tag, ":status"});
            end
        end

        // Writing 0 to the flags (and to read-only bits) changes nothing.
        step(1'b1, A_STATUS, 32'h07, 1'b1, 1'b0, 32'd0, "");
        step(1'b0, A_STATUS, 32'd0, 1'b1, 1'b1, flags, {tag, ":keep"});
        // Writing exactly the set flags clears them.
        step(1'b1, A_STATUS, flags, 1'b1, 1'b0, 32'd0, "");
        step(1'b0, A_STATUS, 32'd0, 1'b1, 1'b1, 32'd0, {tag, ":cleared"});
    endtask

    task automatic bad_ctrl(logic [31:0] d, string tag);
        step(1'b1, A_CTRL, d, 1'b1, 1'b0, 32'd0, "");
        for (int i = 0; i < 8; i++)
            step(1'b0, A_STATUS, 32'd0, 1'b1, 1'b1, 32'd0, tag);
    endtask

    task automatic reset_mid_assert();
        int wcyc, a0;
        pulse_t p;
        step(1'b1, A_WIDTH, 32'd9, 1'b1, 1'b0, 32'd0, "");
        width_reg = 9;
        wcyc    = cyc;
        a0      = wcyc + 1 + G;
        p.start = a0;
        p.len   = 3;               // high on cycles a0..a0+2, dropped by reset
        pulse_q.push_back(p);
        step(1'b1, A_CTRL, START, 1'b1, 1'b0, 32'd0, "");
        for (int c = wcyc + 1; c < a0 + 2; c++)
            step(1'b0, A_STATUS, 32'd0, 1'b0, 1'b1, (c < a0) ? 32'h3 : 32'h5, "rst_mid:status");
        rst_n = 1'b0;
        step(1'b0, A_STATUS, 32'd0, 1'b0, 1'b1, 32'h5, "rst_mid:pre");
        rst_n = 1'b1;
        check("rst_mid:req", {31'd0, rst_req}, 32'd0);
        step(1'b0, A_STATUS, 32'd0, 1'b1, 1'b1, 32'h0, "rst_mid:status0");
        step(1'b0, A_WIDTH, 32'd0, 1'b1, 1'b1, 32'd16, "rst_mid:width16");
        width_reg = 16;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.we_i   = 1'b0;
        bus.addr_i = 4'h0;
        bus.data_i = 32'd0;
        rst_n      = 1'b0;
        @(posedge clk);
        #1;
        check("rst_req_in_reset", {31'd0, rst_req}, 32'd0);
        step(1'b0, A_STATUS, 32'd0, 1'b1, 1'b1, 32'h0,  "rst_status");
        step(1'b0, A_WIDTH,  32'd0, 1'b1, 1'b1, 32'h10, "rst_width");
        rst_n = 1'b1;
        step(1'b0, A_CTRL, 32'd0, 1'b1, 1'b1, 32'h0, "ctrl_reads_zero");

        // Default WIDTH=16, feedback low in ASSERT, released 3 cycles later.
        run_seq(-1, 1'b1, 3, 1'b0, -1, "basic");
        bad_ctrl(32'h1234_0001, "badkey");
        bad_ctrl(32'h5AA5_0000, "nobit0");
        // WIDTH=0, feedback never low.
        run_seq(0, 1'b0, 0, 1'b0, -1, "w0_nofb");
        // Timeouts, with and without feedback seen; second one races clears.
        run_seq(16, 1'b1, 300, 1'b0, -1, "tmo");
        run_seq(-1, 1'b0, 300, 1'b1, -1, "tmo_nofb");
        // Release on the last counted cycle, and one cycle too late.
        run_seq(5, 1'b1, TMO - 1, 1'b1, -1, "edge_done");
        run_seq(-1, 1'b1, TMO, 1'b1, -1, "edge_tmo");
        // Busy start and WIDTH=4 during ASSERT; next start uses 4.
        run_seq(16, 1'b1, 2, 1'b0, 4, "busy_wr");
        run_seq(-1, 1'b1, 2, 1'b0, -1, "next_w4");
        reset_mid_assert();

        for (int i = 0; i < 10; i++) begin
            int wset, rel, bwv;
            bit low, clr;
            wset = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 24));
            low  = 1'($urandom_range(0, 1));
            rel  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(250, 258))
                                               : int'($urandom_range(0, 10));
            clr  = 1'($urandom_range(0, 1));
            bwv  = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 24));
            run_seq(wset, low, rel, clr, bwv, "rand");
        end

        for (int i = 0; i < 4; i++)
            step(1'b0, A_STATUS, 32'd0, 1'b1, 1'b1, 32'h0, "final_idle");
        rd_chk = 1'b0;
        check("pulses_outstanding", 32'(pulse_q.size()), 32'd0);
        check("final_req_low", {31'd0, rst_req}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
